// File: rtl/cache_tag_engine.sv
// cache_tag_engine: set-associative tag/replacement engine for trace-driven
// cache simulation. One request in flight; FIFO or LRU replacement;
// write-back+allocate or write-through+no-allocate, chosen per request.
// Optional statistics counters are built only when CACHE_STATS_EN is defined;
// otherwise the five counter outputs are tied to 0.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE; req_valid outside IDLE is ignored, never
// queued. resp_valid is a single-cycle pulse with no backpressure; resp_hit,
// resp_evict, resp_wb and resp_evict_tag hold until the next response.
module cache_tag_engine #(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_BYTES = 64,
  parameter int NUM_SETS    = 16,
  parameter int ASSOC       = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic              replace_policy,
  input  logic              write_policy,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_evict,
  output logic              resp_wb,
  output logic [ADDR_W-1:0] resp_evict_tag,
  output logic [CNT_W-1:0]  num_reads,
  output logic [CNT_W-1:0]  num_writes,
  output logic [CNT_W-1:0]  num_read_misses,
  output logic [CNT_W-1:0]  num_write_misses,
  output logic [CNT_W-1:0]  num_mem_writes,
  output logic [1:0]        state_dbg
);

  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int IDX_WS = (IDX_W > 0) ? IDX_W : 1;
  localparam int AGE_W  = $clog2(ASSOC);
  localparam int AGE_WS = (AGE_W > 0) ? AGE_W : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESP} state_t;

  state_t state;

  // Per-line state; age 0 is the youngest line of its set.
  logic              line_valid [NUM_SETS][ASSOC];
  logic              line_dirty [NUM_SETS][ASSOC];
  logic [ADDR_W-1:0] line_tag   [NUM_SETS][ASSOC];
  logic [AGE_WS-1:0] line_age   [NUM_SETS][ASSOC];

  // Request latched at accept.
  logic [ADDR_W-1:0] r_addr;
  logic              r_write, r_rp, r_wp;

  // Lookup results registered in LOOKUP.
  logic              hit_q;
  logic [AGE_WS-1:0] hit_way_q, vic_way_q;

  logic [ADDR_W-1:0] addr_sh;
  logic [IDX_WS-1:0] r_idx;
  logic [ADDR_W-1:0] r_tag;
  logic              lk_hit, inv_found;
  logic [AGE_WS-1:0] lk_way, inv_way, old_way, vic_way;
  logic              alloc, vic_valid, vic_dirty;
  logic [AGE_WS-1:0] vic_age, hit_age;
  logic [ADDR_W-1:0] vic_tag;

  assign addr_sh   = r_addr >> OFF_W;
  assign r_idx     = IDX_WS'(addr_sh) & IDX_WS'(NUM_SETS - 1);
  assign r_tag     = r_addr >> (OFF_W + IDX_W);
  assign state_dbg = state;

  // Parallel tag compare plus victim choice: lowest invalid way, else the oldest.
  always_comb begin
    lk_hit    = 1'b0;
    lk_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    old_way   = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (line_valid[r_idx][w] && (line_tag[r_idx][w] == r_tag) && !lk_hit) begin
        lk_hit = 1'b1;
        lk_way = AGE_WS'(w);
      end
      if (!line_valid[r_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = AGE_WS'(w);
      end
      if (line_valid[r_idx][w] && (line_age[r_idx][w] == AGE_WS'(ASSOC - 1)))
        old_way = AGE_WS'(w);
    end
    vic_way = inv_found ? inv_way : old_way;
  end

  // Facts about the chosen victim / hit way, used in UPDATE.
  assign alloc     = !hit_q && (!r_write || !r_wp);
  assign vic_valid = line_valid[r_idx][vic_way_q];
  assign vic_dirty = line_dirty[r_idx][vic_way_q];
  assign vic_age   = line_age[r_idx][vic_way_q];
  assign vic_tag   = line_tag[r_idx][vic_way_q];
  assign hit_age   = line_age[r_idx][hit_way_q];

  // Control FSM together with line-state updates and registered responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_hit       <= 1'b0;
      resp_evict     <= 1'b0;
      resp_wb        <= 1'b0;
      resp_evict_tag <= '0;
      r_addr         <= '0;
      r_write        <= 1'b0;
      r_rp           <= 1'b0;
      r_wp           <= 1'b0;
      hit_q          <= 1'b0;
      hit_way_q      <= '0;
      vic_way_q      <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < ASSOC; w++) begin
          line_valid[s][w] <= 1'b0;
          line_dirty[s][w] <= 1'b0;
          line_tag[s][w]   <= '0;
          line_age[s][w]   <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_addr    <= req_addr;
            r_write   <= req_write;
            r_rp      <= replace_policy;
            r_wp      <= write_policy;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_q     <= lk_hit;
          hit_way_q <= lk_way;
          vic_way_q <= vic_way;
          state     <= UPDATE;
        end
        UPDATE: begin
          if (hit_q) begin
            if (r_rp) begin
              for (int w = 0; w < ASSOC; w++) begin
                if (AGE_WS'(w) == hit_way_q)
                  line_age[r_idx][w] <= '0;
                else if (line_valid[r_idx][w] && (line_age[r_idx][w] < hit_age))
                  line_age[r_idx][w] <= line_age[r_idx][w] + 1'b1;
              end
            end
            if (r_write && !r_wp)
              line_dirty[r_idx][hit_way_q] <= 1'b1;
          end else if (alloc) begin
            // Lines younger than the victim age by one; an invalid victim ages them all.
            for (int w = 0; w < ASSOC; w++) begin
              if ((AGE_WS'(w) != vic_way_q) && line_valid[r_idx][w] &&
                  (!vic_valid || (line_age[r_idx][w] < vic_age)))
                line_age[r_idx][w] <= line_age[r_idx][w] + 1'b1;
            end
            line_valid[r_idx][vic_way_q] <= 1'b1;
            line_dirty[r_idx][vic_way_q] <= r_write;
            line_tag[r_idx][vic_way_q]   <= r_tag;
            line_age[r_idx][vic_way_q]   <= '0;
          end
          resp_hit       <= hit_q;
          resp_evict     <= alloc && vic_valid;
          resp_wb        <= alloc && vic_valid && vic_dirty;
          resp_evict_tag <= (alloc && vic_valid) ? vic_tag : '0;
          resp_valid     <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic mem_write_inc;
  assign mem_write_inc = (alloc && vic_valid && vic_dirty) || (r_write && r_wp);

  // Saturating statistics, updated once per request on the UPDATE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_reads        <= '0;
      num_writes       <= '0;
      num_read_misses  <= '0;
      num_write_misses <= '0;
      num_mem_writes   <= '0;
    end else if (state == UPDATE) begin
      if (r_write) num_writes <= sat_inc(num_writes);
      else         num_reads  <= sat_inc(num_reads);
      if (!hit_q && r_write)  num_write_misses <= sat_inc(num_write_misses);
      if (!hit_q && !r_write) num_read_misses  <= sat_inc(num_read_misses);
      if (mem_write_inc) num_mem_writes <= sat_inc(num_mem_writes);
    end
  end
`else
  assign num_reads        = '0;
  assign num_writes       = '0;
  assign num_read_misses  = '0;
  assign num_write_misses = '0;
  assign num_mem_writes   = '0;
`endif

endmodule

// File: tb/tb_cache_tag_engine.sv
// Directed bench for cache_tag_engine: default-geometry instance plus a
// CNT_W=4 instance fed the same requests to observe counter saturation.
module tb_cache_tag_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic        replace_policy = 1'b0;
  logic        write_policy = 1'b0;

  logic        req_ready, resp_valid, resp_hit, resp_evict, resp_wb;
  logic [31:0] resp_evict_tag;
  logic [15:0] num_reads, num_writes, num_read_misses, num_write_misses, num_mem_writes;
  logic [1:0]  state_dbg;

  logic        s_req_ready, s_resp_valid, s_resp_hit, s_resp_evict, s_resp_wb;
  logic [31:0] s_resp_evict_tag;
  logic [3:0]  s_num_reads, s_num_writes, s_num_read_misses, s_num_write_misses, s_num_mem_writes;
  logic [1:0]  s_state_dbg;

  int checks = 0;
  int failures = 0;
  int m_reads, m_writes, m_rmiss, m_wmiss, m_mem;

  // clock / reset
  always #5 clk = ~clk;

  cache_tag_engine u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .replace_policy(replace_policy),
    .write_policy(write_policy), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_evict(resp_evict), .resp_wb(resp_wb), .resp_evict_tag(resp_evict_tag),
    .num_reads(num_reads), .num_writes(num_writes), .num_read_misses(num_read_misses),
    .num_write_misses(num_write_misses), .num_mem_writes(num_mem_writes),
    .state_dbg(state_dbg)
  );

  cache_tag_engine #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_addr(req_addr), .req_write(req_write), .replace_policy(replace_policy),
    .write_policy(write_policy), .resp_valid(s_resp_valid), .resp_hit(s_resp_hit),
    .resp_evict(s_resp_evict), .resp_wb(s_resp_wb), .resp_evict_tag(s_resp_evict_tag),
    .num_reads(s_num_reads), .num_writes(s_num_writes), .num_read_misses(s_num_read_misses),
    .num_write_misses(s_num_write_misses), .num_mem_writes(s_num_mem_writes),
    .state_dbg(s_state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Counters read 0 when the statistics block is not built.
  function automatic int exp_stat(input int v, input int maxv);
`ifdef CACHE_STATS_EN
    return (v < maxv) ? v : maxv;
`else
    return 0;
`endif
  endfunction

  task automatic check_stats(input string name);
    check({name, ".reads"},   num_reads,        exp_stat(m_reads, 65535));
    check({name, ".writes"},  num_writes,       exp_stat(m_writes, 65535));
    check({name, ".rmiss"},   num_read_misses,  exp_stat(m_rmiss, 65535));
    check({name, ".wmiss"},   num_write_misses, exp_stat(m_wmiss, 65535));
    check({name, ".memwr"},   num_mem_writes,   exp_stat(m_mem, 65535));
    check({name, ".s_reads"}, s_num_reads,      exp_stat(m_reads, 15));
    check({name, ".s_writes"}, s_num_writes,    exp_stat(m_writes, 15));
    check({name, ".s_rmiss"}, s_num_read_misses, exp_stat(m_rmiss, 15));
    check({name, ".s_wmiss"}, s_num_write_misses, exp_stat(m_wmiss, 15));
    check({name, ".s_memwr"}, s_num_mem_writes, exp_stat(m_mem, 15));
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_reads = 0; m_writes = 0; m_rmiss = 0; m_wmiss = 0; m_mem = 0;
    check({name, ".rst_ready"}, req_ready, 1'b1);
    check({name, ".rst_valid"}, resp_valid, 1'b0);
    check({name, ".rst_hit"},   resp_hit, 1'b0);
    check({name, ".rst_evict"}, resp_evict, 1'b0);
    check({name, ".rst_wb"},    resp_wb, 1'b0);
    check({name, ".rst_etag"},  resp_evict_tag, 32'h0);
    check({name, ".rst_state"}, state_dbg, 2'd0);
    check_stats({name, ".rst"});
  endtask

  // One request; junk with req_valid held high is driven while busy and must be ignored.
  task automatic do_req(input string name, input logic [31:0] addr, input logic wr,
                        input logic rp, input logic wp, input logic e_hit,
                        input logic e_evict, input logic e_wb, input logic [31:0] e_tag);
    int  n;
    bit  seen;
    @(negedge clk);
    check({name, ".ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr = addr;
    req_write = wr;
    replace_policy = rp;
    write_policy = wp;
    @(posedge clk);
    #1;
    req_addr = $urandom;
    req_write = 1'($urandom_range(0, 1));
    replace_policy = 1'($urandom_range(0, 1));
    write_policy = 1'($urandom_range(0, 1));
    // n counts rising edges starting with the accept edge
    n = 1;
    seen = 1'b0;
    while (!seen && n < 12) begin
      if (resp_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    req_valid = 1'b0;
    check({name, ".resp_seen"}, seen, 1'b1);
    if (seen) begin
      check({name, ".latency"}, n, 3);
      check({name, ".hit"},   resp_hit, e_hit);
      check({name, ".evict"}, resp_evict, e_evict);
      check({name, ".wb"},    resp_wb, e_wb);
      check({name, ".etag"},  resp_evict_tag, e_tag);
      if (wr) m_writes++; else m_reads++;
      if (!e_hit) begin
        if (wr) m_wmiss++; else m_rmiss++;
      end
      m_mem += int'(e_wb) + int'(wr && wp);
      check_stats(name);
      @(posedge clk);
      #1;
      check({name, ".pulse_end"}, resp_valid, 1'b0);
      check({name, ".ready_back"}, req_ready, 1'b1);
      check({name, ".etag_hold"}, resp_evict_tag, e_tag);
    end
  endtask

  initial begin
    int pulses;

    // cold reads
    do_reset("cold");
    do_req("cold_r0",   32'h0000, 0, 0, 0, 0, 0, 0, 0);
    do_req("cold_r400", 32'h0400, 0, 0, 0, 0, 0, 0, 0);
    do_req("cold_r0b",  32'h0000, 0, 0, 0, 1, 0, 0, 0);

    // FIFO conflict in set 0
    do_reset("fifo");
    for (int t = 1; t <= 4; t++) do_req("fifo_fill", 32'(t) * 32'h400, 0, 0, 0, 0, 0, 0, 0);
    do_req("fifo_t5", 32'h1400, 0, 0, 0, 0, 1, 0, 1);
    do_req("fifo_t1", 32'h0400, 0, 0, 0, 0, 1, 0, 2);

    // LRU
    do_reset("lru");
    for (int t = 1; t <= 4; t++) do_req("lru_fill", 32'(t) * 32'h400, 0, 1, 0, 0, 0, 0, 0);
    do_req("lru_hit1", 32'h0400, 0, 1, 0, 1, 0, 0, 0);
    do_req("lru_t5",   32'h1400, 0, 1, 0, 0, 1, 0, 2);
    do_req("lru_t1",   32'h0400, 0, 1, 0, 1, 0, 0, 0);

    // write-back: dirty allocate, then write-hit dirty
    do_reset("wb");
    do_req("wb_w0", 32'h0000, 1, 0, 0, 0, 0, 0, 0);
    for (int t = 1; t <= 3; t++) do_req("wb_fill", 32'(t) * 32'h400, 0, 0, 0, 0, 0, 0, 0);
    do_req("wb_t4",    32'h1000, 0, 0, 0, 0, 1, 1, 0);
    do_req("wb_whit1", 32'h0400, 1, 0, 0, 1, 0, 0, 0);
    do_req("wb_t5",    32'h1400, 0, 0, 0, 0, 1, 1, 1);

    // write-through: no allocate, no dirty
    do_reset("wt");
    do_req("wt_wmiss", 32'h0000, 1, 0, 1, 0, 0, 0, 0);
    do_req("wt_rmiss", 32'h0000, 0, 0, 1, 0, 0, 0, 0);
    do_req("wt_whit",  32'h0000, 1, 0, 1, 1, 0, 0, 0);
    for (int t = 1; t <= 3; t++) do_req("wt_fill", 32'(t) * 32'h400, 0, 0, 1, 0, 0, 0, 0);
    do_req("wt_t4", 32'h1000, 0, 0, 1, 0, 1, 0, 0);

    // reset during LOOKUP aborts the request and invalidates lines
    do_reset("abort");
    do_req("abort_pre", 32'h0000, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 32'h0000;
    req_write = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reads = 0; m_writes = 0; m_rmiss = 0; m_wmiss = 0; m_mem = 0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) pulses++;
      @(posedge clk);
      #1;
    end
    check("abort.no_pulse", pulses, 0);
    check_stats("abort.cnt");
    do_req("abort_r0", 32'h0000, 0, 0, 0, 0, 0, 0, 0);

    // counter saturation (CNT_W=4 instance stops at 15)
    do_reset("sat");
    for (int i = 0; i < 17; i++) do_req("sat_r", 32'h2000, 0, 0, 0, (i != 0), 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
